// File: rtl/pdm_pkg.sv
// Shared helpers for the PDM audio path: CIC internal width, normalising shift
// and signed saturation limits, used by both the interpolator and the decimator.
package pdm_pkg;

    function automatic int clog2_int(input int value);
        int result;
        result = 0;
        for (int v = 1; v < value; v = v * 2) begin
            result++;
        end
        return result;
    endfunction

    // Bit growth of an N-stage CIC with unity differential delay is R^(N-1) at DC.
    function automatic int cic_shift(input int n, input int r);
        return (n - 1) * clog2_int(r);
    endfunction

    function automatic int cic_acc_width(input int in_w, input int n, input int r);
        return in_w + n + cic_shift(n, r);
    endfunction

    function automatic longint sat_max(input int width);
        return (longint'(1) <<< (width - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

endpackage

// File: rtl/cic_round_sat.sv
// Round-half-up arithmetic right shift followed by saturation to a narrower
// signed width; purely combinational so either CIC direction can reuse it.
module cic_round_sat
    import pdm_pkg::*;
#(
    parameter int IN_W  = 25,
    parameter int OUT_W = 16,
    parameter int SHIFT = 6
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

    // One spare bit beyond both widths keeps the rounding add from wrapping.
    localparam int WW = IN_W + OUT_W + 1;
    localparam logic signed [WW-1:0] ONE   = WW'(1);
    localparam logic signed [WW-1:0] HALF  = (SHIFT == 0) ? '0 : (ONE <<< ((SHIFT > 0) ? SHIFT - 1 : 0));
    localparam logic signed [WW-1:0] MAX_V = WW'(sat_max(OUT_W));
    localparam logic signed [WW-1:0] MIN_V = WW'(sat_min(OUT_W));

    logic signed [WW-1:0] wide;
    logic signed [WW-1:0] rounded;

    always_comb begin
        wide    = WW'(din);
        rounded = (wide + HALF) >>> SHIFT;
        if (rounded > MAX_V) begin
            dout = MAX_V[OUT_W-1:0];
        end else if (rounded < MIN_V) begin
            dout = MIN_V[OUT_W-1:0];
        end else begin
            dout = rounded[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/cic_interpolator.sv
// N-stage CIC interpolator by R: low-rate samples enter a one-entry buffer, the
// downstream out_req tick paces combs (at phase 0) and integrators (every tick).
module cic_interpolator
    import pdm_pkg::*;
#(
    parameter int N         = 3,
    parameter int R         = 8,
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [IN_WIDTH-1:0]  in_sample,
    input  logic                        out_req,
    output logic                        out_valid,
    output logic signed [OUT_WIDTH-1:0] out_sample,
    output logic                        underrun
);

    localparam int ACC_WIDTH = cic_acc_width(IN_WIDTH, N, R);
    localparam int SHIFT     = cic_shift(N, R);
    localparam int PW        = clog2_int(R);

    typedef logic signed [ACC_WIDTH-1:0] acc_t;

    logic [PW-1:0]               phase_q, phase_d;
    logic                        buf_full_q, buf_full_d;
    logic                        in_ready_q, in_ready_d;
    logic signed [IN_WIDTH-1:0]  buf_q, buf_d;
    logic signed [IN_WIDTH-1:0]  last_q, last_d;
    logic signed [OUT_WIDTH-1:0] out_sample_q, out_sample_d;
    logic                        out_valid_q, out_valid_d;
    logic                        underrun_q, underrun_d;
    acc_t                        comb_dly_q [N];
    acc_t                        comb_dly_d [N];
    acc_t                        integ_q [N];
    acc_t                        integ_d [N];
    acc_t                        comb_path [N+1];
    acc_t                        stuffed;
    logic                        consume;
    logic signed [IN_WIDTH-1:0]  consumed;
    logic signed [OUT_WIDTH-1:0] rounded;

    // An empty buffer at a consume tick repeats the previous sample and flags underrun.
    always_comb begin
        consume      = out_req && (phase_q == '0);
        consumed     = buf_full_q ? buf_q : last_q;
        phase_d      = phase_q;
        buf_d        = buf_q;
        buf_full_d   = buf_full_q;
        last_d       = last_q;
        out_sample_d = out_sample_q;
        out_valid_d  = out_req;
        underrun_d   = 1'b0;
        if (out_req) begin
            phase_d      = phase_q + PW'(1);
            out_sample_d = rounded;
        end
        if (consume) begin
            last_d     = consumed;
            buf_full_d = 1'b0;
            underrun_d = !buf_full_q;
        end
        if (in_valid && in_ready_q) begin
            buf_d      = in_sample;
            buf_full_d = 1'b1;
        end
        in_ready_d = !buf_full_d;
    end

    assign comb_path[0] = ACC_WIDTH'(consumed);
    assign stuffed      = consume ? comb_path[N] : '0;

    generate
        for (genvar i = 0; i < N; i++) begin : g_stage
            assign comb_path[i+1] = comb_path[i] - comb_dly_q[i];
            assign comb_dly_d[i]  = consume ? comb_path[i] : comb_dly_q[i];
            if (i == 0) begin : g_first
                assign integ_d[i] = out_req ? (integ_q[i] + stuffed) : integ_q[i];
            end else begin : g_rest
                assign integ_d[i] = out_req ? (integ_q[i] + integ_q[i-1]) : integ_q[i];
            end
        end
    endgenerate

    cic_round_sat #(
        .IN_W  (ACC_WIDTH),
        .OUT_W (OUT_WIDTH),
        .SHIFT (SHIFT)
    ) u_round_sat (
        .din  (integ_q[N-1]),
        .dout (rounded)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q      <= '0;
            buf_q        <= '0;
            buf_full_q   <= 1'b0;
            in_ready_q   <= 1'b1;
            last_q       <= '0;
            out_sample_q <= '0;
            out_valid_q  <= 1'b0;
            underrun_q   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                comb_dly_q[i] <= '0;
                integ_q[i]    <= '0;
            end
        end else begin
            phase_q      <= phase_d;
            buf_q        <= buf_d;
            buf_full_q   <= buf_full_d;
            in_ready_q   <= in_ready_d;
            last_q       <= last_d;
            out_sample_q <= out_sample_d;
            out_valid_q  <= out_valid_d;
            underrun_q   <= underrun_d;
            for (int i = 0; i < N; i++) begin
                comb_dly_q[i] <= comb_dly_d[i];
                integ_q[i]    <= integ_d[i];
            end
        end
    end

    assign in_ready   = in_ready_q;
    assign out_sample = out_sample_q;
    assign out_valid  = out_valid_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_cic_interpolator.sv
// Bench for cic_interpolator (N=3, R=8, 16/16): a direct-form FIR reference
// (taps of the expanded CIC polynomial) checked every cycle, plus directed scenarios.
module tb_cic_interpolator;

    localparam int N     = 3;
    localparam int R     = 8;
    localparam int IN_W  = 16;
    localparam int OUT_W = 16;
    localparam int S     = 6;
    localparam int LAT   = N;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  in_sample;
    logic                    out_req;
    logic                    out_valid;
    logic signed [OUT_W-1:0] out_sample;
    logic                    underrun;

    always #5 clk = ~clk;

    cic_interpolator #(
        .N         (N),
        .R         (R),
        .IN_WIDTH  (IN_W),
        .OUT_WIDTH (OUT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sample  (in_sample),
        .out_req    (out_req),
        .out_valid  (out_valid),
        .out_sample (out_sample),
        .underrun   (underrun)
    );

    int     n_checks = 0;
    int     n_fail   = 0;
    longint h[$];
    longint u_hist[$];

    bit     m_full;
    longint m_buf;
    longint m_last;
    longint m_out;
    int     m_phase;
    bit     m_valid;
    bit     m_under;
    bit     acc_now;
    longint uval;

    int     ready_cnt = 0;
    int     under_cnt = 0;
    int     valid_cnt = 0;
    int     req_cnt   = 0;
    int     mono_dir  = 0;
    longint mono_prev = 0;
    int     mono_viol = 0;

    task automatic checkOutput(input string name, input logic signed [63:0] actual,
                               input logic signed [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
        end
    endtask

    // Impulse response of ((1 - z^-R) / (1 - z^-1))^N: N-fold convolution with R ones.
    function automatic void buildTaps();
        longint nh[$];
        h.delete();
        h.push_back(1);
        for (int st = 0; st < N; st++) begin
            nh.delete();
            for (int i = 0; i < h.size() + R - 1; i++) nh.push_back(0);
            for (int i = 0; i < h.size(); i++)
                for (int j = 0; j < R; j++) nh[i+j] += h[i];
            h = nh;
        end
    endfunction

    function automatic longint expectedSample();
        longint acc;
        int     t;
        acc = 0;
        t   = u_hist.size() - 1;
        for (int j = 0; j < h.size(); j++) begin
            if (t - LAT - j >= 0) acc += h[j] * u_hist[t - LAT - j];
        end
        acc = (acc + (longint'(1) <<< (S - 1))) >>> S;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        return acc;
    endfunction

    function automatic longint tapSum();
        longint s;
        s = 0;
        foreach (h[i]) s += h[i];
        return s;
    endfunction

    // Reference model steps on the clock edge, DUT outputs are compared 1 time unit later.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_full  = 1'b0;
            m_buf   = 0;
            m_last  = 0;
            m_out   = 0;
            m_phase = 0;
            m_valid = 1'b0;
            m_under = 1'b0;
            u_hist.delete();
        end else begin
            acc_now = in_valid && !m_full;
            m_valid = out_req;
            m_under = 1'b0;
            if (out_req) begin
                uval = 0;
                if (m_phase == 0) begin
                    if (m_full) begin
                        m_last = m_buf;
                        m_full = 1'b0;
                    end else begin
                        m_under = 1'b1;
                    end
                    uval = m_last;
                end
                u_hist.push_back(uval);
                m_out   = expectedSample();
                m_phase = (m_phase + 1) % R;
            end
            if (acc_now) begin
                m_buf  = longint'(in_sample);
                m_full = 1'b1;
            end
        end
        #1;
        checkOutput("in_ready", in_ready, !m_full);
        checkOutput("out_valid", out_valid, m_valid);
        checkOutput("underrun", underrun, m_under);
        checkOutput("out_sample", out_sample, m_out);
        if (in_ready === 1'b1) ready_cnt++;
        if (underrun === 1'b1) under_cnt++;
        if (out_valid === 1'b1) begin
            valid_cnt++;
            if (mono_dir > 0 && longint'(out_sample) < mono_prev) mono_viol++;
            if (mono_dir < 0 && longint'(out_sample) > mono_prev) mono_viol++;
            if (mono_dir != 0) mono_prev = longint'(out_sample);
        end
    end

    task automatic applyStimulus(input int nticks, input int period);
        for (int i = 0; i < nticks; i++) begin
            out_req = 1'b1;
            req_cnt++;
            @(negedge clk);
            out_req = 1'b0;
            repeat (period - 1) @(negedge clk);
        end
    endtask

    task automatic applyReset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        out_req  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time %0t exceeded, required completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    int under0;
    int ready0;
    int valid0;
    int req0;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sample = '0;
        out_req   = 1'b0;
        buildTaps();
        checkOutput("tap_count", h.size(), 22);
        checkOutput("tap_sum", tapSum(), 512);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_out_sample", out_sample, 0);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_underrun", underrun, 0);

        $display("[TB] DC 1000, out_req every 4 cycles");
        in_sample = 16'sd1000;
        in_valid  = 1'b1;
        @(negedge clk);
        under0 = under_cnt;
        applyStimulus(4, 4);
        checkOutput("dc1000_first_output", out_sample, 16);
        applyStimulus(36, 4);
        checkOutput("dc1000_settled", out_sample, 1000);
        checkOutput("dc1000_underruns", under_cnt - under0, 0);

        $display("[TB] backpressure, out_req continuous");
        ready0 = ready_cnt;
        under0 = under_cnt;
        applyStimulus(80, 1);
        checkOutput("backpressure_ready_cycles", ready_cnt - ready0, 10);
        checkOutput("backpressure_underruns", under_cnt - under0, 0);

        $display("[TB] underrun after settling at 500");
        in_sample = 16'sd500;
        applyStimulus(48, 4);
        checkOutput("dc500_settled", out_sample, 500);
        in_valid = 1'b0;
        under0   = under_cnt;
        applyStimulus(80, 4);
        checkOutput("underrun_pulses", under_cnt - under0, 9);
        checkOutput("underrun_holds_500", out_sample, 500);

        $display("[TB] reset at phase 5 with a buffered sample");
        in_sample = 16'sd777;
        in_valid  = 1'b1;
        @(negedge clk);
        applyStimulus(5, 4);
        applyReset();
        checkOutput("midreset_in_ready", in_ready, 1);
        checkOutput("midreset_out_sample", out_sample, 0);
        checkOutput("midreset_out_valid", out_valid, 0);
        in_sample = 16'sd200;
        in_valid  = 1'b1;
        @(negedge clk);
        applyStimulus(40, 4);
        checkOutput("after_reset_200", out_sample, 200);

        $display("[TB] full scale positive then negative");
        in_sample = 16'sd32767;
        applyStimulus(48, 4);
        checkOutput("fullscale_pos", out_sample, 32767);
        mono_prev = 32767;
        mono_viol = 0;
        mono_dir  = -1;
        in_sample = -16'sd32768;
        applyStimulus(48, 4);
        mono_dir = 0;
        checkOutput("fullscale_neg", out_sample, -32768);
        checkOutput("fullscale_step_monotonic", mono_viol, 0);

        $display("[TB] step 0 -> 8000");
        applyReset();
        in_sample = 16'sd8000;
        in_valid  = 1'b1;
        @(negedge clk);
        valid0    = valid_cnt;
        req0      = req_cnt;
        mono_prev = 0;
        mono_viol = 0;
        mono_dir  = 1;
        applyStimulus(48, 3);
        mono_dir = 0;
        checkOutput("step8000_final", out_sample, 8000);
        checkOutput("step8000_monotonic", mono_viol, 0);
        checkOutput("step8000_valid_vs_req", valid_cnt - valid0, req_cnt - req0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cic_interpolator.md
CIC_INTERPOLATOR -- requirements
Module: cic_interpolator

Interface
REQ-001 SHALL have parameter N, default 3, number of comb and integrator stages (1..6).
REQ-002 SHALL have parameter R, default 8, interpolation factor, a power of two, 2..64.
REQ-003 SHALL have parameter IN_WIDTH, default 16, signed PCM input width.
REQ-004 SHALL have parameter OUT_WIDTH, default 16, signed PCM output width.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-007 SHALL have port in_valid, input, 1, upstream has a low-rate sample.
REQ-008 SHALL have port in_ready, output, 1, the one-entry input buffer is empty.
REQ-009 SHALL have port in_sample, input, IN_WIDTH, signed low-rate sample.
REQ-010 SHALL have port out_req, input, 1, high-rate tick from the downstream PDM modulator.
REQ-011 SHALL have port out_valid, output, 1, one-cycle pulse: out_sample is updated.
REQ-012 SHALL have port out_sample, output, OUT_WIDTH, signed high-rate sample.
REQ-013 SHALL have port underrun, output, 1, one-cycle pulse: a sample was due while the buffer was empty.

Function
REQ-014 SHALL use an internal width ACC_WIDTH = IN_WIDTH + N + (N-1)*log2(R), with all arithmetic signed two's complement at ACC_WIDTH and sign-extended inputs.
REQ-015 SHALL accept a sample into the one-entry buffer on the cycle in_valid && in_ready, and in_ready SHALL be registered, equal to !buf_full, with no same-cycle bypass.
REQ-016 SHALL keep a phase counter 0..R-1 that advances only on out_req and wraps from R-1 to 0.
REQ-017 SHALL perform a consume event on out_req when phase == 0: if buf_full, take the buffer value and clear buf_full; else reuse the last consumed value and pulse underrun.
REQ-018 SHALL, on a consume event, pass the consumed value through N cascaded comb stages (y = x - x_delayed), updating each comb delay register with that stage's input.
REQ-019 SHALL zero-stuff: the integrator-chain input is the comb output on consume events and 0 on the other R-1 out_req ticks.
REQ-020 SHALL update all N integrators only on out_req, with integrator[i] += old integrator[i-1], and integrator[0] += the zero-stuffed input.
REQ-021 SHALL register out_sample on out_req from the old integrator[N-1], computed as (x + 2^(S-1)) >>> S with S = (N-1)*log2(R); for S = 0 it SHALL pass x unshifted.
REQ-022 SHALL saturate the shifted value to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-023 SHALL assert out_valid for exactly the cycle after each out_req, and hold it low otherwise.
REQ-024 SHALL have unity DC gain, so a constant input X SHALL settle to out_sample == X exactly within (N+1)*R out_req ticks.
REQ-025 SHALL allow a buffer write on the same cycle as a consume event that finds the buffer empty; that sample waits for the next phase-0 tick, and underrun still pulses.
REQ-026 SHALL ignore in_valid while in_ready is low, and SHALL leave the state unchanged on cycles without out_req, except for the buffer write.

Reset
REQ-027 SHALL, while rst_n is low at a clock edge, clear all integrators, comb delays, the last-consumed value, the phase counter, buf_full, out_sample, out_valid and underrun, and SHALL set in_ready to 1 on the following cycle.
REQ-028 SHALL, on a reset asserted mid-frame, discard any buffered sample and restart at phase 0, with no out_valid pulse during reset.

Structure
REQ-029 SHALL take ACC_WIDTH/S derivation helpers and the saturation-limit constants from the shared package pdm_pkg, which the decimator also uses.
REQ-030 SHALL implement rounding plus saturation in one sub-module, cic_round_sat (parameters IN_W, OUT_W, SHIFT), which is reusable by the decimator.
REQ-031 SHALL implement the comb and integrator chains as generate loops, not as separate modules.

Verification
REQ-032 With N=3, R=8, 16/16: hold in_sample=1000 with in_valid, out_req every 4 cycles -> out_sample == 1000 after 32 out_req ticks and thereafter; 0 underrun pulses.
REQ-033 Full scale: constant 32767, then constant -32768 -> outputs settle to exactly 32767 and -32768; no wrap glitch of the opposite sign occurs at any point during the step.
REQ-034 Backpressure: in_valid held high, out_req continuous -> exactly one acceptance per 8 out_req ticks, with in_ready low between acceptances.
REQ-035 Underrun: in_valid low after settling at 500 -> underrun pulses once per 8 out_req ticks; out_sample stays 500.
REQ-036 Reset mid-frame at phase 5 with buf_full=1 -> one cycle later in_ready=1, out_sample=0, out_valid=0; the next accepted 200 settles to 200.
REQ-037 Step 0 -> 8000 -> out_sample is monotonic non-decreasing from 0 to 8000, ends exactly at 8000, and out_valid pulse count equals out_req count.
